// File: rtl/hazard_scoreboard_if.sv
// Pipeline-to-hazard-unit signal bundle: DEC/EXE/MEM/WB register
// indices and controls in, latch controls, forwarding selects and
// multi-cycle unit handshake out.
interface hazard_scoreboard_if #(
  parameter int REG_AW = 5
);
  logic [REG_AW-1:0] rs_DEC;
  logic [REG_AW-1:0] rt_DEC;
  logic              uses_rs_DEC;
  logic              uses_rt_DEC;
  logic [REG_AW-1:0] dst_DEC;
  logic              long_DEC;
  logic [REG_AW-1:0] rs_EXE;
  logic [REG_AW-1:0] rt_EXE;
  logic [REG_AW-1:0] writereg_EXE;
  logic              memtoreg_EXE;
  logic              long_EXE;
  logic [REG_AW-1:0] writereg_MEM;
  logic [REG_AW-1:0] writereg_WB;
  logic              regwrite_MEM;
  logic              regwrite_WB;
  logic              pcsrc_MEM;

  logic              stall;
  logic              clear;
  logic              flush;
  logic [1:0]        forward_a;
  logic [1:0]        forward_b;
  logic              mul_start;
  logic              mul_done;
  logic [REG_AW-1:0] mul_wb_reg;
  logic              mul_busy;

  // Pipeline side: supplies stage information, consumes the controls.
  modport master (
    output rs_DEC, rt_DEC, uses_rs_DEC, uses_rt_DEC, dst_DEC, long_DEC,
    output rs_EXE, rt_EXE, writereg_EXE, memtoreg_EXE, long_EXE,
    output writereg_MEM, writereg_WB, regwrite_MEM, regwrite_WB, pcsrc_MEM,
    input  stall, clear, flush, forward_a, forward_b,
    input  mul_start, mul_done, mul_wb_reg, mul_busy
  );

  // Hazard unit side.
  modport slave (
    input  rs_DEC, rt_DEC, uses_rs_DEC, uses_rt_DEC, dst_DEC, long_DEC,
    input  rs_EXE, rt_EXE, writereg_EXE, memtoreg_EXE, long_EXE,
    input  writereg_MEM, writereg_WB, regwrite_MEM, regwrite_WB, pcsrc_MEM,
    output stall, clear, flush, forward_a, forward_b,
    output mul_start, mul_done, mul_wb_reg, mul_busy
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard and scoreboard controller for the 5-stage pipeline: EXE operand
// forwarding, load-use stall, branch flush, and a busy scoreboard plus
// latency down-counter for the single multi-cycle (mul/div) unit.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | unit free, waiting for a long op in EXE
// S_RUN  | unit busy, latency counter decrementing
// S_DONE | result written this cycle (mul_done), busy bit released at exit
module hazard_scoreboard #(
  parameter int REG_AW  = 5,
  parameter int MUL_LAT = 4
) (
  input logic            clk,
  input logic            reset,
  hazard_scoreboard_if.slave hif
);
  localparam int NREG  = 2 ** REG_AW;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_TC   = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [REG_AW-1:0] dst_q, dst_d;
  logic [NREG-1:0]   busy_q, busy_d;

  logic exe_wr_nz;
  logic mem_fwd_a, mem_fwd_b, wb_fwd_a, wb_fwd_b;
  logic load_haz, score_haz, start;

  assign exe_wr_nz = (hif.writereg_EXE != '0);

  // Forwarding match terms; MEM result is younger so it wins over WB.
  always_comb begin
    mem_fwd_a = hif.regwrite_MEM && (hif.writereg_MEM != '0) && (hif.writereg_MEM == hif.rs_EXE);
    mem_fwd_b = hif.regwrite_MEM && (hif.writereg_MEM != '0) && (hif.writereg_MEM == hif.rt_EXE);
    wb_fwd_a  = hif.regwrite_WB  && (hif.writereg_WB  != '0) && (hif.writereg_WB  == hif.rs_EXE);
    wb_fwd_b  = hif.regwrite_WB  && (hif.writereg_WB  != '0) && (hif.writereg_WB  == hif.rt_EXE);
  end

  // Load-use and scoreboard hazards for the instruction sitting in DEC.
  always_comb begin
    load_haz = hif.memtoreg_EXE && exe_wr_nz &&
               ((hif.uses_rs_DEC && (hif.rs_DEC == hif.writereg_EXE)) ||
                (hif.uses_rt_DEC && (hif.rt_DEC == hif.writereg_EXE)));
    score_haz = (hif.uses_rs_DEC && busy_q[hif.rs_DEC]) ||
                (hif.uses_rt_DEC && busy_q[hif.rt_DEC]) ||
                busy_q[hif.dst_DEC] ||
                (hif.long_DEC && ((state_q != S_IDLE) || hif.long_EXE)) ||
                (hif.long_EXE && exe_wr_nz &&
                 ((hif.uses_rs_DEC && (hif.rs_DEC == hif.writereg_EXE)) ||
                  (hif.uses_rt_DEC && (hif.rt_DEC == hif.writereg_EXE)) ||
                  (hif.dst_DEC == hif.writereg_EXE)));
  end

  // The long op in EXE is dropped if the branch in MEM kills it.
  assign start = !reset && hif.long_EXE && !hif.pcsrc_MEM && (state_q == S_IDLE);

  // Pipeline controls; all forced quiet while reset is held.
  always_comb begin
    hif.forward_a = 2'b00;
    hif.forward_b = 2'b00;
    hif.stall     = 1'b0;
    hif.flush     = 1'b0;
    if (!reset) begin
      if (mem_fwd_a)     hif.forward_a = 2'b10;
      else if (wb_fwd_a) hif.forward_a = 2'b01;
      if (mem_fwd_b)     hif.forward_b = 2'b10;
      else if (wb_fwd_b) hif.forward_b = 2'b01;
      hif.stall = (load_haz || score_haz) && !hif.pcsrc_MEM;
      hif.flush = hif.pcsrc_MEM;
    end
  end

  assign hif.clear      = hif.stall;
  assign hif.mul_start  = start;
  assign hif.mul_busy   = (state_q != S_IDLE);
  assign hif.mul_done   = (state_q == S_DONE);
  assign hif.mul_wb_reg = (state_q == S_DONE) ? dst_q : '0;

  // Next-state for the latency FSM, counter, destination and busy bits.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dst_d   = dst_q;
    busy_d  = busy_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = LAT_LOAD;
          dst_d   = hif.writereg_EXE;
          busy_d[hif.writereg_EXE] = 1'b1;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_TC) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d[dst_q] = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; register 0 can never be marked busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dst_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dst_q   <= dst_d;
      busy_q  <= {busy_d[NREG-1:1], 1'b0};
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (REG_AW=5, MUL_LAT=4).
module tb_hazard_scoreboard;
  logic clk = 1'b0;
  logic reset;
  int n_checks = 0;
  int n_fail   = 0;

  hazard_scoreboard_if #(.REG_AW(5)) hif ();

  hazard_scoreboard #(.REG_AW(5), .MUL_LAT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .hif   (hif.slave)
  );

  always #5 clk = ~clk;

  task automatic drive_idle();
    hif.rs_DEC = '0; hif.rt_DEC = '0; hif.uses_rs_DEC = 0; hif.uses_rt_DEC = 0;
    hif.dst_DEC = '0; hif.long_DEC = 0;
    hif.rs_EXE = '0; hif.rt_EXE = '0; hif.writereg_EXE = '0;
    hif.memtoreg_EXE = 0; hif.long_EXE = 0;
    hif.writereg_MEM = '0; hif.writereg_WB = '0;
    hif.regwrite_MEM = 0; hif.regwrite_WB = 0; hif.pcsrc_MEM = 0;
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1'b1;
    hif.regwrite_MEM = 1; hif.writereg_MEM = 5'd5; hif.rs_EXE = 5'd5; hif.rt_EXE = 5'd5;
    hif.long_EXE = 1; hif.writereg_EXE = 5'd3; hif.memtoreg_EXE = 1;
    hif.uses_rs_DEC = 1; hif.rs_DEC = 5'd3; hif.pcsrc_MEM = 1;
    repeat (2) @(posedge clk);
    #2;
    n_checks++;
    if ({hif.stall, hif.clear, hif.flush, hif.mul_start} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctl: got %b exp 0000", {hif.stall, hif.clear, hif.flush, hif.mul_start});
    end
    n_checks++;
    if ({hif.forward_a, hif.forward_b} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_fwd: got %b exp 0000", {hif.forward_a, hif.forward_b});
    end
    n_checks++;
    if ({hif.mul_busy, hif.mul_done, hif.mul_wb_reg} !== 7'd0) begin
      n_fail++; $display("FAIL reset_mul: got %b exp 0", {hif.mul_busy, hif.mul_done, hif.mul_wb_reg});
    end
    drive_idle();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_forward();
    // wrMEM, rwMEM, wrWB, rwWB, rsEXE, rtEXE, expA, expB
    logic [4:0] wm [5] = '{5'd5, 5'd0, 5'd5, 5'd5, 5'd3};
    logic       rm [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [4:0] ww [5] = '{5'd5, 5'd0, 5'd5, 5'd6, 5'd4};
    logic       rw [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [4:0] rs [5] = '{5'd5, 5'd0, 5'd5, 5'd6, 5'd4};
    logic [4:0] rt [5] = '{5'd5, 5'd0, 5'd6, 5'd5, 5'd3};
    logic [1:0] ea [5] = '{2'b10, 2'b00, 2'b01, 2'b01, 2'b00};
    logic [1:0] eb [5] = '{2'b10, 2'b00, 2'b00, 2'b10, 2'b10};
    for (int i = 0; i < 5; i++) begin
      drive_idle();
      hif.writereg_MEM = wm[i]; hif.regwrite_MEM = rm[i];
      hif.writereg_WB = ww[i];  hif.regwrite_WB = rw[i];
      hif.rs_EXE = rs[i]; hif.rt_EXE = rt[i];
      #1;
      n_checks++;
      if (hif.forward_a !== ea[i]) begin
        n_fail++; $display("FAIL fwd_a[%0d]: got %b exp %b", i, hif.forward_a, ea[i]);
      end
      n_checks++;
      if (hif.forward_b !== eb[i]) begin
        n_fail++; $display("FAIL fwd_b[%0d]: got %b exp %b", i, hif.forward_b, eb[i]);
      end
    end
    drive_idle();
  endtask

  task automatic test_load_use();
    @(posedge clk); #1;
    drive_idle();
    hif.memtoreg_EXE = 1; hif.writereg_EXE = 5'd3;
    hif.uses_rs_DEC = 1; hif.rs_DEC = 5'd3; hif.uses_rt_DEC = 1; hif.rt_DEC = 5'd1; hif.dst_DEC = 5'd4;
    #1;
    n_checks++;
    if ({hif.stall, hif.clear, hif.flush} !== 3'b110) begin
      n_fail++; $display("FAIL lu_stall: got %b exp 110", {hif.stall, hif.clear, hif.flush});
    end
    @(posedge clk); #1;
    hif.memtoreg_EXE = 0; hif.writereg_EXE = '0;
    #1;
    n_checks++;
    if ({hif.stall, hif.clear} !== 2'b00) begin
      n_fail++; $display("FAIL lu_release: got %b exp 00", {hif.stall, hif.clear});
    end
    drive_idle();
  endtask

  task automatic test_scoreboard();
    @(posedge clk); #1;
    drive_idle();
    hif.long_EXE = 1; hif.writereg_EXE = 5'd7;
    hif.uses_rs_DEC = 1; hif.rs_DEC = 5'd7; hif.uses_rt_DEC = 1; hif.rt_DEC = 5'd2; hif.dst_DEC = 5'd8;
    #1;
    n_checks++;
    if ({hif.mul_start, hif.stall} !== 2'b11) begin
      n_fail++; $display("FAIL sb_start: got %b exp 11", {hif.mul_start, hif.stall});
    end
    @(posedge clk); #1;
    hif.long_EXE = 0; hif.writereg_EXE = '0;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({hif.mul_done, hif.stall, hif.mul_busy} !== 3'b011) begin
        n_fail++; $display("FAIL sb_run[%0d]: got %b exp 011", i, {hif.mul_done, hif.stall, hif.mul_busy});
      end
      if (i == 1) begin
        hif.rs_DEC = 5'd1; #1;
        n_checks++;
        if (hif.stall !== 1'b0) begin
          n_fail++; $display("FAIL sb_indep: got %b exp 0", hif.stall);
        end
        hif.rs_DEC = 5'd7;
      end
      @(posedge clk); #2;
    end
    n_checks++;
    if ({hif.mul_done, hif.mul_wb_reg, hif.stall} !== {1'b1, 5'd7, 1'b1}) begin
      n_fail++; $display("FAIL sb_done: got done=%b reg=%0d stall=%b exp 1 7 1", hif.mul_done, hif.mul_wb_reg, hif.stall);
    end
    @(posedge clk); #2;
    n_checks++;
    if ({hif.stall, hif.mul_busy, hif.mul_done} !== 3'b000) begin
      n_fail++; $display("FAIL sb_issue: got %b exp 000", {hif.stall, hif.mul_busy, hif.mul_done});
    end
    drive_idle();
  endtask

  task automatic test_back_to_back();
    bit seen;
    @(posedge clk); #1;
    drive_idle();
    hif.long_EXE = 1; hif.writereg_EXE = 5'd7;
    hif.long_DEC = 1; hif.dst_DEC = 5'd9;
    #1;
    n_checks++;
    if ({hif.mul_start, hif.stall} !== 2'b11) begin
      n_fail++; $display("FAIL b2b_struct: got %b exp 11", {hif.mul_start, hif.stall});
    end
    @(posedge clk); #1;
    hif.long_EXE = 0; hif.writereg_EXE = '0;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (hif.stall !== 1'b1) begin
        n_fail++; $display("FAIL b2b_hold[%0d]: got %b exp 1", i, hif.stall);
      end
      if (i == 1) begin
        hif.long_DEC = 0; hif.dst_DEC = 5'd7; #1;
        n_checks++;
        if (hif.stall !== 1'b1) begin
          n_fail++; $display("FAIL b2b_waw: got %b exp 1", hif.stall);
        end
        hif.long_DEC = 1; hif.dst_DEC = 5'd9;
      end
      @(posedge clk); #2;
    end
    n_checks++;
    if ({hif.stall, hif.mul_busy} !== 2'b00) begin
      n_fail++; $display("FAIL b2b_free: got %b exp 00", {hif.stall, hif.mul_busy});
    end
    @(posedge clk); #1;
    drive_idle();
    hif.long_EXE = 1; hif.writereg_EXE = 5'd9;
    #1;
    n_checks++;
    if (hif.mul_start !== 1'b1) begin
      n_fail++; $display("FAIL b2b_second: got %b exp 1", hif.mul_start);
    end
    @(posedge clk); #1;
    drive_idle();
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      #1;
      if (hif.mul_done === 1'b1) begin
        seen = 1;
        n_checks++;
        if (hif.mul_wb_reg !== 5'd9) begin
          n_fail++; $display("FAIL b2b_wbreg: got %0d exp 9", hif.mul_wb_reg);
        end
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++; $display("FAIL b2b_done_timeout: got no mul_done exp pulse");
    end
    drive_idle();
  endtask

  task automatic test_flush();
    bit seen;
    @(posedge clk); #1;
    drive_idle();
    hif.pcsrc_MEM = 1; hif.long_EXE = 1; hif.memtoreg_EXE = 1; hif.writereg_EXE = 5'd7;
    hif.uses_rs_DEC = 1; hif.rs_DEC = 5'd7;
    #1;
    n_checks++;
    if ({hif.flush, hif.stall, hif.clear, hif.mul_start} !== 4'b1000) begin
      n_fail++; $display("FAIL fl_prio: got %b exp 1000", {hif.flush, hif.stall, hif.clear, hif.mul_start});
    end
    @(posedge clk); #1;
    drive_idle();
    hif.uses_rs_DEC = 1; hif.rs_DEC = 5'd7;
    #1;
    n_checks++;
    if ({hif.mul_busy, hif.stall} !== 2'b00) begin
      n_fail++; $display("FAIL fl_nobusy: got %b exp 00", {hif.mul_busy, hif.stall});
    end
    drive_idle();
    hif.long_EXE = 1; hif.writereg_EXE = 5'd10;
    @(posedge clk); #1;
    drive_idle();
    @(posedge clk); #1;
    hif.pcsrc_MEM = 1;
    @(posedge clk); #1;
    hif.pcsrc_MEM = 0;
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      #1;
      if (hif.mul_done === 1'b1) begin
        seen = 1;
        n_checks++;
        if (hif.mul_wb_reg !== 5'd10) begin
          n_fail++; $display("FAIL fl_wbreg: got %0d exp 10", hif.mul_wb_reg);
        end
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++; $display("FAIL fl_done_timeout: got no mul_done exp pulse");
    end
    drive_idle();
  endtask

  task automatic test_reset_mid_run();
    int done_cnt;
    @(posedge clk); #1;
    drive_idle();
    hif.long_EXE = 1; hif.writereg_EXE = 5'd7;
    @(posedge clk); #1;
    drive_idle();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    hif.uses_rs_DEC = 1; hif.rs_DEC = 5'd7;
    #1;
    n_checks++;
    if ({hif.mul_busy, hif.stall} !== 2'b00) begin
      n_fail++; $display("FAIL rmr_clear: got %b exp 00", {hif.mul_busy, hif.stall});
    end
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #2;
      if (hif.mul_done === 1'b1) done_cnt++;
    end
    n_checks++;
    if (done_cnt != 0) begin
      n_fail++; $display("FAIL rmr_nodone: got %0d pulses exp 0", done_cnt);
    end
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_scoreboard();
    test_back_to_back();
    test_flush();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard and scoreboard controller for the 5-stage pipeline. It replaces the stand-alone bypass selector and the externally driven stall/clear inputs. It generates EXE operand forwarding, load-use stalls, and branch flushes. It also tracks one multi-cycle unit (multiply/divide) with a per-register busy scoreboard and an internal latency counter. It sits beside the controller and drives the pipeline latch controls directly.

## Interface
- REG_AW, 5: register index width; the block tracks 2**REG_AW registers, and register 0 is never hazarded.
- MUL_LAT, 4: multi-cycle unit latency in cycles, from start to result; legal range 2..15.
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- rs_DEC, rt_DEC  in  REG_AW  source registers of the instruction in DEC
- uses_rs_DEC, uses_rt_DEC  in  1  DEC instruction reads rs / rt
- dst_DEC  in  REG_AW  destination of the DEC instruction (0 = none)
- long_DEC  in  1  DEC instruction needs the multi-cycle unit
- rs_EXE, rt_EXE  in  REG_AW  EXE source registers
- writereg_EXE  in  REG_AW  EXE destination
- memtoreg_EXE  in  1  EXE instruction is a load
- long_EXE  in  1  EXE instruction is a multi-cycle op
- writereg_MEM, writereg_WB  in  REG_AW  destinations
- regwrite_MEM, regwrite_WB  in  1  write enables
- pcsrc_MEM  in  1  taken branch resolved in MEM
- stall  out  1  hold PC and the IF/DEC latch
- clear  out  1  insert a bubble into the DEC/EXE latch
- flush  out  1  kill the IF/DEC and DEC/EXE latch contents and the EXE control signals
- forward_a, forward_b  out  2  EXE operand select: 00 register file, 10 MEM aluresult, 01 WB result
- mul_start  out  1  one-cycle start pulse to the multi-cycle unit
- mul_done  out  1  one-cycle pulse; the unit result is written this cycle through its dedicated register file port
- mul_wb_reg  out  REG_AW  destination for mul_done
- mul_busy  out  1  the unit is occupied

## Operation
- **Forwarding** (combinational). For forward_a and rs_EXE:
  - Select 10 if regwrite_MEM, writereg_MEM != 0, and writereg_MEM == rs_EXE.
  - Otherwise select 01 under the same test against WB.
  - Otherwise select 00.
  - MEM has priority over WB. forward_b is identical using rt_EXE.
- **Load-use**: load_haz = memtoreg_EXE and writereg_EXE != 0 and DEC reads writereg_EXE (uses_rs/rs or uses_rt/rt match).
- **Scoreboard**: register busy[2**REG_AW]; bit 0 is hardwired to 0.
- **Score hazard**: score_haz is true if any of these hold:
  - a DEC read register is busy;
  - dst_DEC is busy (WAW);
  - long_DEC while mul_busy or long_EXE (structural);
  - a DEC read register or dst_DEC equals writereg_EXE while long_EXE (issue in flight).
- **Stall and flush outputs**:
  - stall = (load_haz or score_haz) and not pcsrc_MEM.
  - clear = stall.
  - flush = pcsrc_MEM.
  - flush overrides stall.
- **Start**: the multi-cycle op starts at the edge where long_EXE and not flush and not mul_busy hold. mul_start is high combinationally that cycle.
- **Effect of start at that edge**:
  - busy[writereg_EXE] is set, except for register 0.
  - The counter is loaded with MUL_LAT-1.
  - dst_r is set to writereg_EXE.
  - mul_busy is set.
- **Count FSM**:
  - IDLE → RUN on start.
  - RUN: the counter decrements each cycle.
  - RUN → DONE when the counter reaches 0.
  - DONE lasts one cycle: mul_done=1 and mul_wb_reg=dst_r. At the edge ending DONE, busy[dst_r] and mul_busy are cleared and the FSM returns to IDLE.
- **pcsrc_MEM during RUN/DONE**: no effect. The in-flight op is older than the branch and completes.
- **Reset**: busy all 0, FSM IDLE, counter 0, mul_busy 0, mul_done 0, mul_wb_reg 0. While reset is asserted, stall, clear and flush are 0, mul_start is 0, and forward_a/forward_b are 00.

## Timing
- Forwarding, stall, clear, flush and mul_start are combinational from same-cycle inputs.
- Start at edge T: mul_busy=1 from T. mul_done is high in cycle T+MUL_LAT-1 .. T+MUL_LAT, i.e. MUL_LAT cycles after T inclusive of the DONE cycle. busy is clear from edge T+MUL_LAT.
- A DEC reader of dst_r stalls through the DONE cycle and proceeds the cycle after.
- A second long op can start no earlier than the edge after DONE; there is no back-to-back overlap.
- A load-use stall lasts exactly one cycle unless a score hazard persists.
- Reset mid-RUN: no mul_done pulse is ever produced for the aborted op.

## Test plan
- **Forward priority**: writereg_MEM=writereg_WB=rs_EXE=5, both regwrite=1 → forward_a=10. With writereg=0 and both regwrite=1 → 00.
- **Load-use**: lw r3 in EXE, DEC add r4,r3,r1 → stall=clear=1 for one cycle, 0 the next.
- **Scoreboard, MUL_LAT=4**:
  - mul to r7 starts at T → mul_done=1 with mul_wb_reg=7 in cycle T+3.
  - A dependent add r8,r7,r2 in DEC stalls through T+3 and issues at T+4.
  - An independent add is not stalled.
- **Structural/WAW**: two back-to-back mul ops → the second stalls until after DONE. A non-long write to busy r7 stalls.
- **Branch flush**: pcsrc_MEM=1 with long_EXE=1 and load_haz → flush=1, stall=0, mul_start=0, busy unchanged. A flush during RUN still yields mul_done.
- **Reset mid-RUN**: assert reset at T+1 → busy all 0 and mul_busy=0 after the edge, and no mul_done follows.
